// File: rtl/dfe_pkg.sv
// dfe_pkg: shared parameters, state codes and entry layout for the data-frequency-extraction core
// Contents: log2 helper, array/hash geometry, MASK, occurrence entry struct, FSM state codes
// shared with the crossbar switch.
package dfe_pkg;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    localparam int LENGTH_ARRAY      = 100;
    localparam int LAW               = log2(LENGTH_ARRAY);
    localparam int DATA_INDEX_WIDTH  = 32;
    localparam int BIT_ON_TAILS      = 7;
    localparam int LENGTH_HASH_ARRAY = 1 << BIT_ON_TAILS;
    localparam logic [DATA_INDEX_WIDTH-1:0] MASK = DATA_INDEX_WIDTH'(LENGTH_HASH_ARRAY - 1);
    localparam int CNT_W             = LAW + 1;

    typedef struct packed {
        logic                        valid;
        logic [DATA_INDEX_WIDTH-1:0] key;
        logic [CNT_W-1:0]            count;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    localparam logic [3:0] ST_WAIT         = 4'd0;
    localparam logic [3:0] ST_WAIT_INT     = 4'd1;
    localparam logic [3:0] ST_FETCH        = 4'd2;
    localparam logic [3:0] ST_WAIT_DATA    = 4'd3;
    localparam logic [3:0] ST_FIRST_TEMP   = 4'd4;
    localparam logic [3:0] ST_WAIT_TEMP    = 4'd5;
    localparam logic [3:0] ST_RD_HASH      = 4'd6;
    localparam logic [3:0] ST_COLL_CAL     = 4'd7;
    localparam logic [3:0] ST_HASH_BUILD   = 4'd8;

    typedef enum logic [3:0] {
        S_WAIT       = ST_WAIT,
        S_WAIT_INT   = ST_WAIT_INT,
        S_FETCH      = ST_FETCH,
        S_WAIT_DATA  = ST_WAIT_DATA,
        S_FIRST_TEMP = ST_FIRST_TEMP,
        S_WAIT_TEMP  = ST_WAIT_TEMP,
        S_RD_HASH    = ST_RD_HASH,
        S_COLL_CAL   = ST_COLL_CAL,
        S_HASH_BUILD = ST_HASH_BUILD
    } state_t;

endpackage

// File: rtl/hash_build_ctrl_if.sv
// hash_build_ctrl_if: data-array read port and hash-table port of the hash-build controller
// master (controller): drives data_rd_en/data_rd_addr, hash_rd_en/hash_wr_en/hash_addr/hash_wr_data;
//                      receives data_valid/data_in, hash_rd_data (one cycle after hash_rd_en).
// slave (memories):    the mirror image.
interface hash_build_ctrl_if;
    import dfe_pkg::*;
    logic                        data_rd_en;
    logic [LAW-1:0]              data_rd_addr;
    logic                        data_valid;
    logic [DATA_INDEX_WIDTH-1:0] data_in;
    logic                        hash_rd_en;
    logic                        hash_wr_en;
    logic [BIT_ON_TAILS-1:0]     hash_addr;
    logic [ENTRY_W-1:0]          hash_wr_data;
    logic [ENTRY_W-1:0]          hash_rd_data;

    modport master (
        output data_rd_en, data_rd_addr, hash_rd_en, hash_wr_en, hash_addr, hash_wr_data,
        input  data_valid, data_in, hash_rd_data
    );

    modport slave (
        input  data_rd_en, data_rd_addr, hash_rd_en, hash_wr_en, hash_addr, hash_wr_data,
        output data_valid, data_in, hash_rd_data
    );
endinterface

// File: rtl/hash_probe_unit.sv
// hash_probe_unit: linear-probe address and count, entry capture, key compare and count update
// Ports: clk, rst (sync active-low); init loads probe_addr=key&MASK and clears probe_cnt;
// capture latches rd_entry; step advances the probe (wrapping 127->0); outputs probe_addr,
// last_probe (probe_cnt==127), collide (captured entry valid with another key) and wr_entry.
module hash_probe_unit
    import dfe_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        capture,
    input  logic                        step,
    input  logic [DATA_INDEX_WIDTH-1:0] key,
    input  entry_t                      rd_entry,
    output logic [BIT_ON_TAILS-1:0]     probe_addr,
    output logic                        last_probe,
    output logic                        collide,
    output entry_t                      wr_entry
);
    logic [BIT_ON_TAILS-1:0] probe_addr_q, probe_addr_d, probe_cnt_q, probe_cnt_d;
    entry_t                  entry_q, entry_d;
    logic                    hit;

    always_comb begin
        probe_addr_d = init ? BIT_ON_TAILS'(key & MASK) : step ? probe_addr_q + 1'b1 : probe_addr_q;
        probe_cnt_d  = init ? '0 : step ? probe_cnt_q + 1'b1 : probe_cnt_q;
        entry_d      = capture ? rd_entry : entry_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            probe_addr_q <= '0;
            probe_cnt_q  <= '0;
            entry_q      <= '0;
        end else begin
            probe_addr_q <= probe_addr_d;
            probe_cnt_q  <= probe_cnt_d;
            entry_q      <= entry_d;
        end
    end

    assign probe_addr = probe_addr_q;
    assign last_probe = &probe_cnt_q;
    assign hit        = entry_q.valid && entry_q.key == key;
    assign collide    = entry_q.valid && entry_q.key != key;
    // An empty slot starts a fresh count of one; a hit bumps the stored count.
    assign wr_entry   = {1'b1, key, hit ? entry_q.count + 1'b1 : CNT_W'(1)};
endmodule

// File: rtl/hash_build_ctrl.sv
// hash_build_ctrl: per-processor hash-table builder with linear probing and crossbar park/resume
// Ports: clk, rst (sync active-low); start_index/end_index pass window; bus (hash_build_ctrl_if.master)
// carries the data-array and hash-table ports; state/index exported to the crossbar; interrupt parks
// the walk at the next Fetch, cont (rising edge) starts or resumes; waiting, sticky done/overflow,
// collision_cnt. Optional macro HASH_COLLISION_STAT_EN builds the saturating collision counter;
// without it collision_cnt is tied to 0.
module hash_build_ctrl
    import dfe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LAW-1:0]       start_index,
    input  logic [LAW-1:0]       end_index,
    hash_build_ctrl_if.master    bus,
    output logic [3:0]           state,
    output logic [LAW-1:0]       index,
    input  logic                 interrupt,
    input  logic                 cont,
    output logic                 waiting,
    output logic                 done,
    output logic                 overflow,
    output logic [15:0]          collision_cnt
);
    state_t                      state_q, state_d;
    logic [LAW-1:0]              index_q, index_d, data_rd_addr_q, data_rd_addr_d;
    logic [DATA_INDEX_WIDTH-1:0] key_q, key_d;
    entry_t                      hash_wr_data_q, hash_wr_data_d, wr_entry;
    logic                        waiting_q, waiting_d, done_q, done_d, overflow_q, overflow_d;
    logic                        data_rd_en_q, data_rd_en_d, hash_rd_en_q, hash_rd_en_d;
    logic                        hash_wr_en_q, hash_wr_en_d, int_pend_q, int_pend_d, cont_q;
    logic                        cont_rise, last_probe, collide;
    logic [BIT_ON_TAILS-1:0]     probe_addr;

    hash_probe_unit u_probe (
        .clk        (clk),
        .rst        (rst),
        .init       (state_q == S_FIRST_TEMP),
        .capture    (state_q == S_RD_HASH),
        .step       (state_q == S_COLL_CAL && collide && !last_probe),
        .key        (key_q),
        .rd_entry   (bus.hash_rd_data),
        .probe_addr (probe_addr),
        .last_probe (last_probe),
        .collide    (collide),
        .wr_entry   (wr_entry)
    );

    always_comb begin
        cont_rise      = cont & ~cont_q;
        state_d        = state_q;
        index_d        = index_q;
        key_d          = key_q;
        data_rd_addr_d = data_rd_addr_q;
        hash_wr_data_d = hash_wr_data_q;
        done_d         = done_q;
        overflow_d     = overflow_q;
        int_pend_d     = int_pend_q | interrupt;
        data_rd_en_d   = 1'b0;
        hash_wr_en_d   = 1'b0;
        case (state_q)
            S_WAIT: if (cont_rise && !done_q) begin
                index_d = start_index;
                state_d = S_FETCH;
            end
            S_WAIT_INT: state_d = cont_rise ? S_FETCH : S_WAIT_INT;
            S_FETCH: begin
                int_pend_d = 1'b0;
                if (interrupt || int_pend_q) state_d = S_WAIT_INT;
                else begin
                    data_rd_en_d   = 1'b1;
                    data_rd_addr_d = index_q;
                    state_d        = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: if (bus.data_valid) begin
                key_d   = bus.data_in;
                state_d = S_FIRST_TEMP;
            end
            S_FIRST_TEMP: state_d = S_WAIT_TEMP;
            S_WAIT_TEMP:  state_d = S_RD_HASH;
            S_RD_HASH:    state_d = S_COLL_CAL;
            S_COLL_CAL: begin
                if (!collide) begin
                    hash_wr_en_d   = 1'b1;
                    hash_wr_data_d = wr_entry;
                    state_d        = S_HASH_BUILD;
                end else if (last_probe) begin
                    // Whole table probed without a free slot: drop the element.
                    overflow_d = 1'b1;
                    state_d    = S_HASH_BUILD;
                end else state_d = S_WAIT_TEMP;
            end
            S_HASH_BUILD: if (index_q == end_index) begin
                done_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                index_d = index_q + 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_WAIT;
        endcase
        // Enables are registered so they are visible in the state they belong to.
        hash_rd_en_d = state_d == S_WAIT_TEMP;
        waiting_d    = state_d == S_WAIT || state_d == S_WAIT_INT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_WAIT;
            index_q        <= '0;
            key_q          <= '0;
            data_rd_addr_q <= '0;
            hash_wr_data_q <= '0;
            waiting_q      <= 1'b1;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            data_rd_en_q   <= 1'b0;
            hash_rd_en_q   <= 1'b0;
            hash_wr_en_q   <= 1'b0;
            int_pend_q     <= 1'b0;
            cont_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            key_q          <= key_d;
            data_rd_addr_q <= data_rd_addr_d;
            hash_wr_data_q <= hash_wr_data_d;
            waiting_q      <= waiting_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            data_rd_en_q   <= data_rd_en_d;
            hash_rd_en_q   <= hash_rd_en_d;
            hash_wr_en_q   <= hash_wr_en_d;
            int_pend_q     <= int_pend_d;
            cont_q         <= cont;
        end
    end

`ifdef HASH_COLLISION_STAT_EN
    logic [15:0] collision_cnt_q, collision_cnt_d;

    always_comb
        collision_cnt_d = (state_q == S_COLL_CAL && collide && collision_cnt_q != 16'hFFFF)
                          ? collision_cnt_q + 1'b1 : collision_cnt_q;

    always_ff @(posedge clk) collision_cnt_q <= !rst ? '0 : collision_cnt_d;

    assign collision_cnt = collision_cnt_q;
`else
    assign collision_cnt = '0;
`endif

    assign state            = state_q;
    assign index            = index_q;
    assign waiting          = waiting_q;
    assign done             = done_q;
    assign overflow         = overflow_q;
    assign bus.data_rd_en   = data_rd_en_q;
    assign bus.data_rd_addr = data_rd_addr_q;
    assign bus.hash_rd_en   = hash_rd_en_q;
    assign bus.hash_wr_en   = hash_wr_en_q;
    assign bus.hash_addr    = probe_addr;
    assign bus.hash_wr_data = hash_wr_data_q;
endmodule

// File: tb/tb_hash_build_ctrl.sv
// tb_hash_build_ctrl: scoreboard bench for hash_build_ctrl with behavioural linear-probe model
module tb_hash_build_ctrl;
    import dfe_pkg::*;

    logic clk = 1'b0, rst = 1'b0, interrupt = 1'b0, cont = 1'b0;
    logic [LAW-1:0] start_index = '0, end_index = '0;
    logic [3:0] state;
    logic [LAW-1:0] index;
    logic waiting, done, overflow;
    logic [15:0] collision_cnt;

    hash_build_ctrl_if bus();

    hash_build_ctrl dut (
        .clk(clk), .rst(rst), .start_index(start_index), .end_index(end_index), .bus(bus),
        .state(state), .index(index), .interrupt(interrupt), .cont(cont), .waiting(waiting),
        .done(done), .overflow(overflow), .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [DATA_INDEX_WIDTH-1:0] dmem [LENGTH_ARRAY];
    logic [ENTRY_W-1:0] tbl [LENGTH_HASH_ARRAY];
    logic [ENTRY_W-1:0] model_tbl [LENGTH_HASH_ARRAY];
    logic [BIT_ON_TAILS+ENTRY_W-1:0] exp_q [$];
    int m_coll = 0, exp_probes = 0;
    logic m_ovf = 1'b0, preload_req = 1'b0;
    int hrd_total = 0, drd_total = 0, wr_total = 0, hrd_base = 0;
    logic [LAW-1:0] last_rd_addr = '0;
    int dly = 0;
    logic [LAW-1:0] raddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: probe from key mod 128 upward until an empty slot or the same key; full table drops it.
    function automatic int model_insert(input logic [DATA_INDEX_WIDTH-1:0] key);
        logic [ENTRY_W-1:0] e, n;
        int a;
        for (int i = 0; i < LENGTH_HASH_ARRAY; i++) begin
            a = (int'(key % LENGTH_HASH_ARRAY) + i) % LENGTH_HASH_ARRAY;
            e = model_tbl[a];
            if (!e[ENTRY_W-1] || e[ENTRY_W-2:CNT_W] == key) begin
                n = {1'b1, key, e[ENTRY_W-1] ? e[CNT_W-1:0] + CNT_W'(1) : CNT_W'(1)};
                model_tbl[a] = n;
                exp_q.push_back({BIT_ON_TAILS'(a), n});
                m_coll += i;
                return i + 1;
            end
        end
        m_ovf = 1'b1;
        m_coll += LENGTH_HASH_ARRAY;
        return LENGTH_HASH_ARRAY;
    endfunction

    function automatic logic [15:0] exp_coll();
`ifdef HASH_COLLISION_STAT_EN
        return m_coll > 65535 ? 16'hFFFF : 16'(m_coll);
`else
        return 16'd0;
`endif
    endfunction

    initial for (int i = 0; i < LENGTH_HASH_ARRAY; i++) tbl[i] = '0;

    // Hash table memory: registered read, write on hash_wr_en.
    always @(posedge clk) begin
        if (preload_req)
            for (int i = 0; i < LENGTH_HASH_ARRAY; i++) tbl[i] <= {1'b1, DATA_INDEX_WIDTH'(1000 + i), CNT_W'(1)};
        else if (bus.hash_wr_en) tbl[bus.hash_addr] <= bus.hash_wr_data;
        if (bus.hash_rd_en) bus.hash_rd_data <= tbl[bus.hash_addr];
    end

    // Data array: responds 1..3 cycles after the request.
    always @(posedge clk) begin
        bus.data_valid <= 1'b0;
        if (!rst) dly <= 0;
        else if (bus.data_rd_en) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.data_valid <= 1'b1;
                bus.data_in    <= dmem[bus.data_rd_addr];
            end else begin
                dly   <= int'($urandom_range(1, 2));
                raddr <= bus.data_rd_addr;
            end
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                bus.data_valid <= 1'b1;
                bus.data_in    <= dmem[raddr];
            end
        end
    end

    // Monitor: every write the DUT presents is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst && bus.hash_rd_en) hrd_total++;
        if (rst && bus.data_rd_en) begin
            drd_total++;
            last_rd_addr = bus.data_rd_addr;
        end
        if (rst && bus.hash_wr_en) begin
            wr_total++;
            if (exp_q.size() == 0) chk("unexpected_write", {bus.hash_addr, bus.hash_wr_data}, '0);
            else begin
                logic [BIT_ON_TAILS+ENTRY_W-1:0] x;
                x = exp_q.pop_front();
                chk("wr_addr", 64'(bus.hash_addr), 64'(x[BIT_ON_TAILS+ENTRY_W-1:ENTRY_W]));
                chk("wr_data", 64'(bus.hash_wr_data), 64'(x[ENTRY_W-1:0]));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_index", index, 0);
        chk("rst_waiting", waiting, 1);
        chk("rst_done_ovf", {done, overflow}, 0);
        chk("rst_enables", {bus.data_rd_en, bus.hash_rd_en, bus.hash_wr_en}, 0);
        chk("rst_addr_data", {bus.data_rd_addr, bus.hash_addr, bus.hash_wr_data}, 0);
        chk("rst_coll", collision_cnt, 0);
        rst = 1'b1;
        m_ovf = 1'b0;
        m_coll = 0;
        exp_probes = 0;
        hrd_base = hrd_total;
    endtask

    task automatic start_pass(input int s, input int e, input int hold);
        for (int i = s; i <= e; i++) exp_probes += model_insert(dmem[i]);
        start_index = LAW'(s);
        end_index = LAW'(e);
        @(posedge clk);
        #1 cont = 1'b1;
        repeat (hold) @(posedge clk);
        #1 cont = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done", done, 1);
    endtask

    task automatic end_checks();
        repeat (3) @(negedge clk);
        chk("idle_state", state, 0);
        chk("idle_waiting", waiting, 1);
        chk("overflow", overflow, m_ovf);
        chk("collision_cnt", collision_cnt, exp_coll());
        chk("hash_reads", hrd_total - hrd_base, exp_probes);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        int n, snap, wsnap;
        for (int i = 0; i < LENGTH_ARRAY; i++) dmem[i] = $urandom_range(0, 400);
        for (int i = 0; i < LENGTH_HASH_ARRAY; i++) model_tbl[i] = '0;

        do_reset();

        // Directed pass: 5 and 133 share slot 5, second 5 hits.
        dmem[0] = 5; dmem[1] = 133; dmem[2] = 5; dmem[3] = 7;
        start_pass(0, 3, 1);
        wait_done(300);
        end_checks();
        chk("tbl5", tbl[5], {1'b1, 32'd5, 8'd2});
        chk("tbl6", tbl[6], {1'b1, 32'd133, 8'd1});
        chk("tbl7", tbl[7], {1'b1, 32'd7, 8'd1});

        // Randomised passes against the model.
        for (int p = 0; p < 6; p++) begin
            int s, l;
            s = $urandom_range(40, 80);
            l = $urandom_range(0, 11);
            do_reset();
            start_pass(s, s + l, 1);
            wait_done(2000);
            end_checks();
        end

        // Interrupt right after HashBuild of element 10, resume later.
        do_reset();
        start_pass(8, 14, 1);
        n = 0;
        while (!(state == ST_HASH_BUILD && index == 10) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_hb10", n < 300, 1);
        @(posedge clk);
        #1 interrupt = 1'b1;
        @(posedge clk);
        #1 interrupt = 1'b0;
        chk("int_state", state, ST_WAIT_INT);
        chk("int_waiting", waiting, 1);
        chk("int_no_rd", bus.data_rd_en, 0);
        snap = drd_total;
        repeat (5) @(posedge clk);
        #1 cont = 1'b1;
        @(posedge clk);
        #1 cont = 1'b0;
        chk("resume_state", state, ST_FETCH);
        @(posedge clk);
        #1;
        chk("resume_rd", {bus.data_rd_en, bus.data_rd_addr}, {1'b1, 7'd11});
        chk("parked_no_rd", drd_total, snap);
        wait_done(2000);
        end_checks();

        // cont held high for 4 cycles: a single pass only.
        do_reset();
        snap = drd_total;
        start_pass(0, 0, 4);
        wait_done(300);
        repeat (20) @(negedge clk);
        end_checks();
        chk("one_pass_reads", drd_total - snap, 1);

        // Reset while reading the table: the element's write never happens.
        do_reset();
        wsnap = wr_total;
        start_index = 30;
        end_index = 30;
        @(posedge clk);
        #1 cont = 1'b1;
        @(posedge clk);
        #1 cont = 1'b0;
        n = 0;
        while (state != ST_RD_HASH && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rdhash", n < 50, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_state", state, 0);
        chk("rst_mid_wr", bus.hash_wr_en, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_write", wr_total, wsnap);

        // Full table: both elements probe 128 slots and are dropped.
        do_reset();
        @(posedge clk);
        #1 preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
        for (int i = 0; i < LENGTH_HASH_ARRAY; i++) model_tbl[i] = {1'b1, DATA_INDEX_WIDTH'(1000 + i), CNT_W'(1)};
        dmem[20] = 9;
        dmem[21] = 9;
        wsnap = wr_total;
        start_pass(20, 21, 1);
        wait_done(3000);
        end_checks();
        chk("ovf_no_write", wr_total, wsnap);
        chk("ovf_index_adv", last_rd_addr, 21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
